// File: rtl/dma_device_port.sv
// Peripheral-side responder for one 8237A DMA channel.
// An internal FIFO sits between the device core and the DMA bus cycle.
module dma_device_port #(
  parameter int DEPTH       = 8,
  parameter int DREQ_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     dir,
  input  logic [7:0]               dev_wdata,
  input  logic                     dev_wr,
  input  logic                     dev_rd,
  output logic [7:0]               dev_rdata,
  output logic                     dev_full,
  output logic                     dev_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dreq,
  input  logic                     dack,
  input  logic                     ior_n,
  input  logic                     iow_n,
  input  logic                     eop_n,
  input  logic [7:0]               db_in,
  output logic [7:0]               db_out,
  output logic                     db_oe,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DREQ_THRESH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_XFER    = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_next, room_next;
  logic [2:0]    state, state_next;
  logic          dir_q, dir_next;
  logic          strobe_low, commit, bus_push, bus_pop;
  logic          push_req, pop_req, do_push, do_pop;
  logic          is_full, is_empty, overrun, underrun, eop_hit, dreq_next;
  logic [7:0]    push_data;

  // Bus handshake: a transfer is one DACK-qualified strobe assertion (IOR for
  // dir=0, IOW for dir=1). It commits on the first clk seen in REQ; the strobe
  // must rise (or DACK drop) before the channel can commit again.
  assign is_full    = (cnt == DEPTH_C);
  assign is_empty   = (cnt == '0);
  assign strobe_low = dir_q ? ~iow_n : ~ior_n;
  assign commit     = enable & (state == S_REQ) & dack & strobe_low;
  assign bus_push   = commit & dir_q;
  assign bus_pop    = commit & ~dir_q;
  assign eop_hit    = enable & dack & ~eop_n;

  // The bus side wins the single FIFO port on each side when both try at once.
  assign push_req  = bus_push | dev_wr;
  assign push_data = bus_push ? db_in : dev_wdata;
  assign pop_req   = bus_pop | dev_rd;
  assign do_pop    = pop_req & ~is_empty;
  assign do_push   = push_req & (~is_full | do_pop);
  assign overrun   = bus_push & ~do_push;
  assign underrun  = bus_pop & is_empty;
  assign cnt_next  = cnt + CW'(do_push) - CW'(do_pop);
  assign room_next = DEPTH_C - cnt_next;

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = S_IDLE;
    end else if (eop_hit) begin
      state_next = S_DONE;
    end else begin
      case (state)
        S_IDLE:    state_next = S_REQ;
        S_REQ:     if (commit) state_next = S_XFER;
        S_XFER:    state_next = S_RECOVER;
        S_RECOVER: if (!strobe_low || !dack) state_next = S_REQ;
        S_DONE:    state_next = S_DONE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  assign dir_next = (state == S_IDLE) ? dir : dir_q;

  // dreq looks ahead at the occupancy after this clk's pushes and pops.
  always_comb begin
    dreq_next = 1'b0;
    if (state_next == S_REQ || state_next == S_RECOVER) begin
      dreq_next = dir_next ? (room_next >= THRESH_C) : (cnt_next >= THRESH_C);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      dir_q  <= 1'b0;
      dreq   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      dir_q <= dir_next;
      dreq  <= dreq_next;
      cnt   <= cnt_next;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (!enable) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else begin
        if (eop_hit)             done <= 1'b1;
        if (overrun || underrun) err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Bus read data is driven with no register so IOR sees it immediately.
  assign db_oe     = (state != S_IDLE) & ~dir_q & dack & ~ior_n;
  assign db_out    = db_oe ? (is_empty ? 8'hFF : mem[rd_ptr]) : 8'h00;
  assign dev_rdata = mem[rd_ptr];
  assign dev_full  = is_full;
  assign dev_empty = is_empty;
  assign count     = cnt;
  assign state_dbg = state;

endmodule

// File: tb/tb_dma_device_port.sv
// Bench for dma_device_port: directed scenarios plus randomized streams
// checked against a transaction-level queue model of the FIFO and flags.
module tb_dma_device_port;

  localparam int DEPTH = 8;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_XFER = 3'd2,
                         ST_RECOVER = 3'd3, ST_DONE = 3'd4;

  logic       clk, reset, enable, dir;
  logic [7:0] dev_wdata, dev_rdata, db_in, db_out;
  logic       dev_wr, dev_rd, dev_full, dev_empty;
  logic [3:0] count;
  logic       dreq, dack, ior_n, iow_n, eop_n, db_oe, done, err;
  logic [2:0] state_dbg;

  logic [7:0] exp_q[$];
  logic       exp_err, exp_done;
  int         checks, errors;

  dma_device_port #(.DEPTH(DEPTH), .DREQ_THRESH(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir),
    .dev_wdata(dev_wdata), .dev_wr(dev_wr), .dev_rd(dev_rd),
    .dev_rdata(dev_rdata), .dev_full(dev_full), .dev_empty(dev_empty),
    .count(count), .dreq(dreq), .dack(dack), .ior_n(ior_n), .iow_n(iow_n),
    .eop_n(eop_n), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // drivers
  task automatic dev_write(input logic [7:0] b);
    dev_wr = 1'b1;
    dev_wdata = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    tick();
    dev_wr = 1'b0;
  endtask

  task automatic dev_read(output logic [7:0] b);
    dev_rd = 1'b1;
    #1 b = dev_rdata;
    tick();
    dev_rd = 1'b0;
  endtask

  task automatic bus_pulse(input bit wr, input int low, input logic [7:0] data,
                           input bit eop, output logic [7:0] obs_out,
                           output logic obs_oe);
    logic [7:0] tmp;
    dack = 1'b1;
    if (wr) iow_n = 1'b0; else ior_n = 1'b0;
    db_in = data;
    eop_n = ~eop;
    #1;
    obs_out = db_out;
    obs_oe  = db_oe;
    if (wr) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(data); else exp_err = 1'b1;
    end else begin
      if (exp_q.size() > 0) tmp = exp_q.pop_front(); else exp_err = 1'b1;
    end
    if (eop) exp_done = 1'b1;
    repeat (low) tick();
    dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1; eop_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic disarm();
    enable = 1'b0;
    tick();
    exp_err = 1'b0;
    exp_done = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (dev_empty !== 1'b1 || dev_full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b expected 1/0", dev_empty, dev_full); end
    checks++; if (dreq !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ctrl: dreq=%b done=%b err=%b expected 000", dreq, done, err); end
    checks++; if (db_oe !== 1'b0 || db_out !== 8'h00) begin errors++; $display("FAIL reset_bus: oe=%b out=%h expected 0/00", db_oe, db_out); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_read_stream();
    logic [7:0] vals [3];
    logic [7:0] obs, exp;
    logic oe;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    dir = 1'b0;
    for (int i = 0; i < 3; i++) dev_write(vals[i]);
    enable = 1'b1;
    tick();
    checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL rd_dreq_arm: got %b expected 1", dreq); end
    for (int i = 0; i < 3; i++) begin
      exp = exp_q[0];
      bus_pulse(1'b0, 2, 8'h00, 1'b0, obs, oe);
      checks++; if (obs !== exp || exp !== vals[i]) begin errors++; $display("FAIL rd_data%0d: got %h expected %h", i, obs, vals[i]); end
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rd_oe%0d: got %b expected 1", i, oe); end
      checks++; if (db_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_off%0d: got %b expected 0", i, db_oe); end
      checks++; if (dreq !== (exp_q.size() >= 1)) begin errors++; $display("FAIL rd_dreq%0d: got %b expected %b", i, dreq, exp_q.size() >= 1); end
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rd_count_end: got %0d expected 0", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", err); end
    disarm();
  endtask

  task automatic test_write_eop();
    logic [7:0] obs, exp;
    logic oe;
    dir = 1'b1;
    enable = 1'b1;
    tick();
    checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL wr_dreq_arm: got %b expected 1", dreq); end
    for (int i = 0; i < 4; i++) bus_pulse(1'b1, 2, 8'hA0 + 8'(i), i == 3, obs, oe);
    checks++; if (done !== exp_done) begin errors++; $display("FAIL wr_done: got %b expected %b", done, exp_done); end
    checks++; if (state_dbg !== ST_DONE) begin errors++; $display("FAIL wr_state_done: got %0d expected %0d", state_dbg, ST_DONE); end
    checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL wr_count: got %0d expected %0d", count, exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      dev_read(obs);
      checks++; if (obs !== exp || exp !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wr_order%0d: got %h expected %h", i, obs, 8'hA0 + 8'(i)); end
      checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL wr_dreq_after_eop%0d: got %b expected 0", i, dreq); end
    end
    disarm();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_clear: got %b expected 0", done); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL wr_state_idle: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_overrun();
    logic [7:0] obs;
    logic oe;
    for (int i = 0; i < DEPTH; i++) dev_write(8'($urandom_range(0, 255)));
    dir = 1'b1;
    enable = 1'b1;
    tick();
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL ovr_dreq: got %b expected 0", dreq); end
    checks++; if (dev_full !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b expected 1", dev_full); end
    bus_pulse(1'b1, 2, 8'($urandom_range(0, 255)), 1'b0, obs, oe);
    checks++; if (err !== exp_err) begin errors++; $display("FAIL ovr_err: got %b expected %b", err, exp_err); end
    checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", count, exp_q.size()); end
    disarm();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_err_clear: got %b expected 0", err); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] nb, head, obs, exp;
    nb = 8'($urandom_range(0, 255));
    dir = 1'b1;
    enable = 1'b1;
    tick();
    dev_rd = 1'b1; dack = 1'b1; iow_n = 1'b0; db_in = nb;
    #1 obs = dev_rdata;
    head = exp_q.pop_front();
    exp_q.push_back(nb);
    checks++; if (obs !== head) begin errors++; $display("FAIL sim_head_before: got %h expected %h", obs, head); end
    tick();
    dev_rd = 1'b0;
    dack = 1'b0; iow_n = 1'b1;
    repeat (2) tick();
    checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL sim_count: got %0d expected %0d", count, exp_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_err: got %b expected 0", err); end
    disarm();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      dev_read(obs);
      checks++; if (obs !== exp) begin errors++; $display("FAIL sim_drain: got %h expected %h", obs, exp); end
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL sim_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_underrun_long();
    logic [7:0] exp, obs, b;
    dir = 1'b0;
    enable = 1'b1;
    tick();
    dack = 1'b1; ior_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp = (exp_q.size() > 0) ? exp_q[0] : 8'hFF;
      checks++; if (db_out !== exp) begin errors++; $display("FAIL und_out%0d: got %h expected %h", i, db_out, exp); end
      checks++; if (db_oe !== 1'b1) begin errors++; $display("FAIL und_oe%0d: got %b expected 1", i, db_oe); end
      if (i == 0) exp_err = 1'b1;
      if (i == 2) begin
        b = 8'($urandom_range(0, 255));
        dev_wr = 1'b1; dev_wdata = b;
        exp_q.push_back(b);
      end
      tick();
      dev_wr = 1'b0;
    end
    dack = 1'b0; ior_n = 1'b1;
    repeat (2) tick();
    checks++; if (err !== exp_err) begin errors++; $display("FAIL und_err: got %b expected %b", err, exp_err); end
    checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL und_single_commit: count got %0d expected %0d", count, exp_q.size()); end
    disarm();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      dev_read(obs);
      checks++; if (obs !== exp) begin errors++; $display("FAIL und_drain: got %h expected %h", obs, exp); end
    end
  endtask

  task automatic test_random_stream(input bit d);
    logic [7:0] obs, exp;
    logic oe;
    bit exp_dreq;
    dir = d;
    enable = 1'b1;
    tick();
    for (int n = 0; n < 40; n++) begin
      // device side and bus side take turns at random
      if ($urandom_range(0, 1) == 0) begin
        if (d == 1'b0) dev_write(8'($urandom_range(0, 255)));
        else if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          dev_read(obs);
          checks++; if (obs !== exp) begin errors++; $display("FAIL rnd%0d_devrd%0d: got %h expected %h", d, n, obs, exp); end
        end
      end else if (d == 1'b0 && exp_q.size() > 0) begin
        exp = exp_q[0];
        bus_pulse(1'b0, $urandom_range(1, 3), 8'h00, 1'b0, obs, oe);
        checks++; if (obs !== exp) begin errors++; $display("FAIL rnd%0d_busrd%0d: got %h expected %h", d, n, obs, exp); end
      end else if (d == 1'b1 && exp_q.size() < DEPTH) begin
        bus_pulse(1'b1, $urandom_range(1, 3), 8'($urandom_range(0, 255)), 1'b0, obs, oe);
      end
      exp_dreq = d ? ((DEPTH - exp_q.size()) >= 1) : (exp_q.size() >= 1);
      checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_count%0d: got %0d expected %0d", d, n, count, exp_q.size()); end
      checks++; if (dreq !== exp_dreq) begin errors++; $display("FAIL rnd%0d_dreq%0d: got %b expected %b", d, n, dreq, exp_dreq); end
    end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", d, err, exp_err); end
    disarm();
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      dev_read(obs);
      checks++; if (obs !== exp) begin errors++; $display("FAIL rnd%0d_drain: got %h expected %h", d, obs, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] tmp;
    for (int i = 0; i < 4; i++) dev_write(8'($urandom_range(0, 255)));
    dir = 1'b0;
    enable = 1'b1;
    tick();
    dack = 1'b1; ior_n = 1'b0;
    tick();
    tmp = exp_q.pop_front();
    checks++; if (state_dbg !== ST_XFER || count !== 4'(exp_q.size())) begin errors++; $display("FAIL rst_setup: state=%0d count=%0d expected %0d/%0d", state_dbg, count, ST_XFER, exp_q.size()); end
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (count !== 4'd0 || dev_empty !== 1'b1 || dev_full !== 1'b0) begin errors++; $display("FAIL rst_async_fifo: count=%0d empty=%b full=%b expected 0/1/0", count, dev_empty, dev_full); end
    checks++; if (dreq !== 1'b0 || db_oe !== 1'b0 || db_out !== 8'h00) begin errors++; $display("FAIL rst_async_bus: dreq=%b oe=%b out=%h expected 0/0/00", dreq, db_oe, db_out); end
    checks++; if (state_dbg !== ST_IDLE || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_async_state: state=%0d done=%b err=%b expected 0/0/0", state_dbg, done, err); end
    dack = 1'b0; ior_n = 1'b1; enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_err = 1'b0; exp_done = 1'b0;
    reset = 1'b0; enable = 1'b0; dir = 1'b0;
    dev_wdata = 8'h00; dev_wr = 1'b0; dev_rd = 1'b0;
    dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1; eop_n = 1'b1; db_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    tick();
    test_reset();
    test_read_stream();
    test_write_eop();
    test_overrun();
    test_simultaneous();
    test_underrun_long();
    test_random_stream(1'b0);
    test_random_stream(1'b1);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
